// File: rtl/mult_seq_pkg.sv
// Shared encodings and sizes for the sequential shift-and-add multiplier.
// The optional zero-skip early exit is enabled with MULT_SEQ_ZERO_SKIP_EN.
package mult_seq_pkg;
    localparam int WIDTH_DEF = 4;
    localparam int CNT_W     = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/mult_seq_if.sv
// Start/busy/done handshake plus operand and product buses of the multiplier.
interface mult_seq_if
    import mult_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);
    logic               start;
    logic [WIDTH-1:0]   multiplicand;
    logic [WIDTH-1:0]   multiplier;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] product;

    modport master (output start, multiplicand, multiplier,
                    input  busy, done, product);
    modport slave  (input  start, multiplicand, multiplier,
                    output busy, done, product);
endinterface

// File: rtl/adder_4bit.sv
// Team 4-bit ripple adder; the multiplier's only arithmetic resource.
module adder_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
endmodule

// File: rtl/mult_seq_dp.sv
// Multiplier datapath: A/Q/M registers, one shared adder, and the per-step shift.
// With MULT_SEQ_ZERO_SKIP_EN it also flags exhausted multiplier bits and aligns the early result.
module mult_seq_dp
    import mult_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   m_in,
    input  logic [WIDTH-1:0]   q_in,
`ifdef MULT_SEQ_ZERO_SKIP_EN
    input  logic [CNT_W-1:0]   cnt_nxt,
    output logic               skip,
    output logic [2*WIDTH-1:0] skip_res,
`endif
    output logic [2*WIDTH-1:0] step_res
);
    logic [WIDTH-1:0] a_q, a_d, q_q, q_d, m_q, m_d;
    logic [WIDTH-1:0] addend, sum;
    logic             cout;

    adder_4bit u_add (
        .a    (a_q),
        .b    (addend),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cout)
    );

    // The carry lands in A's MSB on the shift, so C is zero after every
    // step and needs no storage of its own.
    always_comb begin
        addend   = q_q[0] ? m_q : '0;
        step_res = {cout, sum, q_q[WIDTH-1:1]};
        a_d      = a_q;
        q_d      = q_q;
        m_d      = m_q;
        if (load) begin
            a_d = '0;
            q_d = q_in;
            m_d = m_in;
        end else if (step) begin
            {a_d, q_d} = step_res;
        end
    end

`ifdef MULT_SEQ_ZERO_SKIP_EN
    logic [WIDTH-1:0] live_mask;

    // Low WIDTH-count bits of Q are multiplier bits not yet examined.
    always_comb begin
        live_mask = {WIDTH{1'b1}} >> cnt_nxt;
        skip      = (step_res[WIDTH-1:0] & live_mask) == '0;
        skip_res  = step_res >> (CNT_W'(WIDTH) - cnt_nxt);
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q <= '0;
            q_q <= '0;
            m_q <= '0;
        end else begin
            a_q <= a_d;
            q_q <= q_d;
            m_q <= m_d;
        end
    end
endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequential unsigned multiplier controller: IDLE/RUN/DONE FSM and step counter.
// Define MULT_SEQ_ZERO_SKIP_EN to finish early once the remaining multiplier bits are zero.
module mult_seq_ctrl
    import mult_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic      clk,
    input  logic      rst,
    mult_seq_if.slave bus
);
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d, cnt_nxt;
    logic               busy_q, busy_d, done_q, done_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic               load, step;
    logic [2*WIDTH-1:0] step_res;
`ifdef MULT_SEQ_ZERO_SKIP_EN
    logic               skip;
    logic [2*WIDTH-1:0] skip_res;
`endif

    mult_seq_dp #(.WIDTH(WIDTH)) u_dp (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .step     (step),
        .m_in     (bus.multiplicand),
        .q_in     (bus.multiplier),
`ifdef MULT_SEQ_ZERO_SKIP_EN
        .cnt_nxt  (cnt_nxt),
        .skip     (skip),
        .skip_res (skip_res),
`endif
        .step_res (step_res)
    );

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        product_d = product_q;
        load      = 1'b0;
        step      = 1'b0;
        cnt_nxt   = count_q + 1'b1;
        case (state_q)
            // DONE accepts start exactly like IDLE, so back-to-back ops skip IDLE.
            IDLE, DONE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    count_d = '0;
                    state_d = RUN;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            RUN: begin
                step    = 1'b1;
                count_d = cnt_nxt;
                if (cnt_nxt == CNT_W'(WIDTH)) begin
                    state_d   = DONE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    product_d = step_res;
                end
`ifdef MULT_SEQ_ZERO_SKIP_EN
                else if (skip) begin
                    state_d   = DONE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    product_d = skip_res;
                end
`endif
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            product_q <= product_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.product = product_q;
endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Scoreboard bench for mult_seq_ctrl: products and done latency checked per operation.
module tb_mult_seq_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mult_seq_if bus ();
    mult_seq_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    int         vecs = 0;
    int         errs = 0;
    logic [7:0] sb[$];

    // Cycles from the capture edge to the edge entering DONE.
    function automatic int exp_lat(input logic [3:0] q);
`ifdef MULT_SEQ_ZERO_SKIP_EN
        int l = 1;
        for (int i = 0; i < 4; i++) if (q[i]) l = i + 1;
        return l;
`else
        return 4;
`endif
    endfunction

    // Returns n = index of the negedge (counted from the capture edge) where done shows.
    task automatic wait_done(input int n0, output int lat, output logic [7:0] prod,
                             output logic busy_at, output int gaps);
        int n = n0;
        lat = -1; prod = '0; busy_at = 1'b0; gaps = 0;
        while (n < n0 + 40) begin
            @(negedge clk);
            n++;
            if (bus.done) begin
                lat = n; prod = bus.product; busy_at = bus.busy;
                break;
            end
            if (!bus.busy) gaps++;
        end
    endtask

    task automatic run_op(input logic [3:0] m, input logic [3:0] q, output int lat,
                          output logic [7:0] prod, output logic busy_at, output int gaps);
        @(negedge clk);
        bus.start = 1'b1; bus.multiplicand = m; bus.multiplier = q;
        sb.push_back(8'(m) * 8'(q));
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.multiplicand = 4'($urandom);
        bus.multiplier   = 4'($urandom);
        wait_done(0, lat, prod, busy_at, gaps);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.start = 1'b0; bus.multiplicand = '0; bus.multiplier = '0;
        #12;
        vecs++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.product !== 8'h00) begin
            errs++;
            $display("FAIL reset: busy=%b done=%b product=%h required 0 0 00", bus.busy, bus.done, bus.product);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic;
        int lat, gaps; logic [7:0] prod, exp; logic busy_at;
        run_op(4'd3, 4'd5, lat, prod, busy_at, gaps);
        exp = sb.pop_front();
        vecs++; if (prod !== exp) begin errs++; $display("FAIL basic product: got %h required %h", prod, exp); end
        vecs++; if (lat !== exp_lat(4'd5) + 1) begin errs++; $display("FAIL basic latency: got %0d required %0d", lat, exp_lat(4'd5) + 1); end
        vecs++; if (busy_at !== 1'b0 || gaps !== 0) begin errs++; $display("FAIL basic busy: busy_at_done=%b gaps=%0d required 0 0", busy_at, gaps); end
        repeat (3) begin
            @(negedge clk);
            vecs++;
            if (bus.product !== 8'h0F || bus.done !== 1'b0) begin
                errs++; $display("FAIL basic hold: product=%h done=%b required 0f 0", bus.product, bus.done);
            end
        end
    endtask

    task automatic test_max;
        int lat, gaps; logic [7:0] prod, exp; logic busy_at;
        logic [3:0] mv[3] = '{4'd15, 4'd0, 4'd5};
        logic [3:0] qv[3] = '{4'd15, 4'd9, 4'd8};
        for (int i = 0; i < 3; i++) begin
            run_op(mv[i], qv[i], lat, prod, busy_at, gaps);
            exp = sb.pop_front();
            vecs++; if (prod !== exp) begin errs++; $display("FAIL max product %0d: got %h required %h", i, prod, exp); end
            vecs++; if (lat !== exp_lat(qv[i]) + 1) begin errs++; $display("FAIL max latency %0d: got %0d required %0d", i, lat, exp_lat(qv[i]) + 1); end
        end
    endtask

    task automatic test_abort;
        int lat, gaps; logic [7:0] prod, exp; logic busy_at;
        @(negedge clk);
        bus.start = 1'b1; bus.multiplicand = 4'd7; bus.multiplier = 4'd6;
        sb.push_back(8'h2A);
        @(posedge clk); #1 bus.start = 1'b0;
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        #1;
        vecs++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.product !== 8'h00) begin
            errs++; $display("FAIL abort: busy=%b done=%b product=%h required 0 0 00", bus.busy, bus.done, bus.product);
        end
        sb.delete();
        @(negedge clk); rst = 1'b0;
        run_op(4'd7, 4'd6, lat, prod, busy_at, gaps);
        exp = sb.pop_front();
        vecs++; if (prod !== exp) begin errs++; $display("FAIL abort rerun product: got %h required %h", prod, exp); end
        vecs++; if (lat !== exp_lat(4'd6) + 1) begin errs++; $display("FAIL abort rerun latency: got %0d required %0d", lat, exp_lat(4'd6) + 1); end
    endtask

    task automatic test_busy_ignore;
        int lat, gaps, extra; logic [7:0] prod, exp; logic busy_at;
        @(negedge clk);
        bus.start = 1'b1; bus.multiplicand = 4'd2; bus.multiplier = 4'd3;
        sb.push_back(8'h06);
        @(posedge clk); #1 bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.multiplicand = 4'd9; bus.multiplier = 4'd9;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(2, lat, prod, busy_at, gaps);
        exp = sb.pop_front();
        vecs++; if (prod !== exp) begin errs++; $display("FAIL busy_ignore product: got %h required %h", prod, exp); end
        vecs++; if (lat !== exp_lat(4'd3) + 1) begin errs++; $display("FAIL busy_ignore latency: got %0d required %0d", lat, exp_lat(4'd3) + 1); end
        extra = 0;
        repeat (8) begin @(negedge clk); if (bus.done || bus.busy) extra++; end
        vecs++; if (extra !== 0) begin errs++; $display("FAIL busy_ignore second op: %0d active cycles, required 0", extra); end
    endtask

    task automatic test_back_to_back;
        int lat1, lat2, g1, g2; logic [7:0] p1, p2, exp; logic b1, b2;
        @(negedge clk);
        bus.start = 1'b1; bus.multiplicand = 4'd2; bus.multiplier = 4'd3;
        sb.push_back(8'h06);
        @(posedge clk); #1;
        bus.multiplicand = 4'd4; bus.multiplier = 4'd4;
        sb.push_back(8'h10);
        wait_done(0, lat1, p1, b1, g1);
        @(posedge clk); #1 bus.start = 1'b0;
        wait_done(0, lat2, p2, b2, g2);
        exp = sb.pop_front();
        vecs++; if (p1 !== exp) begin errs++; $display("FAIL b2b first product: got %h required %h", p1, exp); end
        exp = sb.pop_front();
        vecs++; if (p2 !== exp) begin errs++; $display("FAIL b2b second product: got %h required %h", p2, exp); end
        vecs++; if (lat2 !== exp_lat(4'd4) + 1) begin errs++; $display("FAIL b2b done spacing: got %0d required %0d", lat2, exp_lat(4'd4) + 1); end
        vecs++; if (b1 !== 1'b0 || g2 !== 0) begin errs++; $display("FAIL b2b bubble: busy_at_done=%b gaps=%0d required 0 0", b1, g2); end
    endtask

    task automatic test_random;
        int lat, gaps; logic [7:0] prod, exp; logic busy_at;
        logic [3:0] m, q;
        for (int i = 0; i < 12; i++) begin
            m = 4'($urandom); q = 4'($urandom);
            run_op(m, q, lat, prod, busy_at, gaps);
            exp = sb.pop_front();
            vecs++;
            if (prod !== exp || lat !== exp_lat(q) + 1) begin
                errs++;
                $display("FAIL random %0d (%0d*%0d): product %h lat %0d required %h lat %0d", i, m, q, prod, lat, exp, exp_lat(q) + 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max();
        test_abort();
        test_busy_ignore();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/mult_seq_ctrl.md
Name: mult_seq_ctrl

Overview:
- Sequential shift-and-add multiplier controller that time-shares one instance of the team's adder_4bit across WIDTH iterations.
- Computes an unsigned WIDTH x WIDTH -> 2*WIDTH product.
- Uses a start/busy/done handshake.
- Sits between the lab's operand switches / stimulus logic and the result display; the adder is the only arithmetic resource.

Parameters:
- WIDTH, 4, operand width. Must equal the adder_4bit width; there is no other legal value in this revision.
- CNT_W, 3, iteration counter width. Equals ceil(log2(WIDTH+1)).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- multiplicand  input  WIDTH  operand M; captured on accepted start.
- multiplier  input  WIDTH  operand Q; captured on accepted start.
- busy  output  1  high while iterating.
- done  output  1  one-cycle pulse; product valid.
- product  output  2*WIDTH  last completed result; held until the next completion.

Behaviour:
- Reset (async, rst=1) sets:
  - state=IDLE
  - busy=0, done=0, product=0
  - internal A=0, Q=0, M=0, C=0, count=0
- States:
  - IDLE: if start, capture M and Q, clear A and C, set count=0, go to RUN. Otherwise stay.
  - RUN: one step per clock (see Datapath step). count increments. After step WIDTH, go to DONE.
  - DONE: done=1 for exactly this cycle. product was registered on the edge entering DONE.
    - If start is high here, accept it (same as IDLE) and go to RUN. Back-to-back operation has no idle bubble.
    - Otherwise go to IDLE.
- Datapath step:
  - Adder inputs: augend=A, addend=(Q[0] ? M : 0), carryin tied 0.
  - {C,A} <= adder {cout,sum}.
  - Then {C,A,Q} is shifted right by 1 with 0 entering the MSB, all on the same edge.
  - Net effect per edge: {A,Q} <= {cout,sum,Q[WIDTH-1:1]}.
- Latency:
  - start accepted at edge k; done high in the cycle following edge k+WIDTH.
  - busy is high after edges k through k+WIDTH-1 and low in the DONE cycle.
- Completion: product <= {A,Q} computed by the final step, loaded on the edge entering DONE.
- start while in RUN is ignored; operands are not re-captured.
- Operand inputs may change freely after the capture edge.
- rst asserted mid-RUN aborts immediately to the reset values above. No done is produced and product is cleared.
- Arithmetic bounds:
  - max 15*15=225 (8'hE1). A never overflows beyond C.
  - C is always 0 after the shift.

Optional Feature:
- Macro MULT_SEQ_ZERO_SKIP_EN.
- When defined, RUN checks after each step whether the unconsumed multiplier bits (the shifted Q bits not yet examined) are all zero.
  - If they are, go to DONE on that same edge.
  - product <= step result shifted right by the remaining step count r = WIDTH - count_after_step, zero-filled.
  - Latency = position of highest set multiplier bit + 1, minimum 1. multiplier=0 gives done after 1 cycle.
- When undefined, latency is always exactly WIDTH. The check logic and shifter are not built.
- Results are identical in both builds.

Decomposition:
- mult_seq_pkg (shared localparams/include) holds:
  - state encodings: IDLE=2'd0, RUN=2'd1, DONE=2'd2
  - WIDTH_DEF=4, CNT_W
- The adder is the existing adder_4bit, instantiated once.
- One natural sub-module: mult_seq_dp, holding the A/Q/M/C registers, the shift, and the optional skip shifter.
- The FSM and counter stay in mult_seq_ctrl.

Test Plan:
- Reset mid-RUN: start M=7, Q=6, then pulse rst after 2 cycles -> busy=0, done=0, product=0 immediately; next start M=7, Q=6 -> product=8'h2A.
- Basic: M=3, Q=5 start pulse -> busy high for 4 cycles, done pulse 4 cycles after the capture edge, product=8'h0F held until the next completion.
- Max: M=15, Q=15 -> product=8'hE1. M=0, Q=9 -> product=8'h00 with full latency (non-skip build).
- Busy-ignore: start M=2, Q=3, then assert start with M=9, Q=9 during RUN -> product=8'h06; no second done.
- Back-to-back: start held high through DONE with new M=4, Q=4 -> done pulses 5 cycles apart, products 8'h06 then 8'h10, no IDLE cycle.
- MULT_SEQ_ZERO_SKIP_EN defined:
  - M=5, Q=1 -> done 1 cycle after capture, product=8'h05.
  - M=5, Q=0 -> 1 cycle, 8'h00.
  - M=5, Q=8 -> 4 cycles, 8'h28.
